// File: rtl/linear_proj_pkg.sv
// Shared types and widths for the linear projection / attention datapath, including the input-matrix loader.
// Optional build macro MAT_LOADER_LAST_CHECK_EN is consumed by in_mat_loader.
package linear_proj_pkg;

  localparam int ADDR_WIDTH_A = 10;
  localparam int DATA_WIDTH_A = 32;

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} mat_loader_state_t;

  // Counter width for a load of n words; never narrower than one bit.
  function automatic int mat_loader_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/in_mat_loader.sv
// Streams NUM_WORDS words into the input-matrix BRAM two at a time (ports A/B), one write per odd beat, 1-cycle latency.
// s_ready is high for the whole LOAD phase (no internal backpressure); macro MAT_LOADER_LAST_CHECK_EN enables s_last checking.
module in_mat_loader
  import linear_proj_pkg::*;
#(
  parameter int NUM_WORDS = 64,
  parameter int BASE_ADDR = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_start,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [DATA_WIDTH_A-1:0] s_data,
  input  logic                    s_last,
  output logic                    mat_ena,
  output logic                    mat_wea,
  output logic [ADDR_WIDTH_A-1:0] mat_addra,
  output logic [DATA_WIDTH_A-1:0] mat_dina,
  output logic                    mat_enb,
  output logic                    mat_web,
  output logic [ADDR_WIDTH_A-1:0] mat_addrb,
  output logic [DATA_WIDTH_A-1:0] mat_dinb,
  output logic                    busy,
  output logic                    load_done,
  output logic                    mat_ready,
  output logic                    load_err
);

  localparam int MAT_LOADER_CNT_W = mat_loader_cnt_w(NUM_WORDS);
  localparam logic [MAT_LOADER_CNT_W-1:0] LAST_IDX = MAT_LOADER_CNT_W'(NUM_WORDS - 1);

  mat_loader_state_t           r_state;
  logic [MAT_LOADER_CNT_W-1:0] r_cnt;
  logic [DATA_WIDTH_A-1:0]     r_pair;
  logic                        r_s_ready;
  logic                        r_busy;
  logic                        r_done;
  logic                        r_mat_ready;
  logic                        r_wr;
  logic [ADDR_WIDTH_A-1:0]     r_addra;
  logic [ADDR_WIDTH_A-1:0]     r_addrb;
  logic [DATA_WIDTH_A-1:0]     r_dina;
  logic [DATA_WIDTH_A-1:0]     r_dinb;

  logic                        w_acc;
  logic                        w_start;
  logic                        w_last_beat;
  logic [ADDR_WIDTH_A-1:0]     w_addr_odd;

  assign w_acc       = s_valid && r_s_ready;
  assign w_start     = load_start && ((r_state == IDLE) || (r_state == DONE));
  assign w_last_beat = (r_cnt == LAST_IDX);
  // The odd beat's own address; its even partner sits one below (BASE_ADDR is even).
  assign w_addr_odd  = ADDR_WIDTH_A'(BASE_ADDR) + ADDR_WIDTH_A'(r_cnt);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_pair      <= '0;
      r_s_ready   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_mat_ready <= 1'b0;
      r_wr        <= 1'b0;
      r_addra     <= '0;
      r_addrb     <= '0;
      r_dina      <= '0;
      r_dinb      <= '0;
    end else begin
      r_wr   <= 1'b0;
      r_done <= 1'b0;
      if (w_start) begin
        r_state     <= LOAD;
        r_cnt       <= '0;
        r_pair      <= '0;
        r_s_ready   <= 1'b1;
        r_busy      <= 1'b1;
        r_mat_ready <= 1'b0;
      end else begin
        case (r_state)
          LOAD: begin
            if (w_acc) begin
              if (!r_cnt[0]) begin
                r_pair <= s_data;
              end else begin
                r_wr    <= 1'b1;
                r_addra <= w_addr_odd - ADDR_WIDTH_A'(1);
                r_addrb <= w_addr_odd;
                r_dina  <= r_pair;
                r_dinb  <= s_data;
              end
              if (w_last_beat) begin
                r_state   <= FLUSH;
                r_cnt     <= '0;
                r_s_ready <= 1'b0;
                r_busy    <= 1'b0;
              end else begin
                r_cnt <= r_cnt + MAT_LOADER_CNT_W'(1);
              end
            end
          end
          // Final pair is being written this cycle; completion is announced once it lands.
          FLUSH: begin
            r_state     <= DONE;
            r_done      <= 1'b1;
            r_mat_ready <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef MAT_LOADER_LAST_CHECK_EN
  logic r_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_start) begin
      r_err <= 1'b0;
    end else if (w_acc && (s_last != w_last_beat)) begin
      r_err <= 1'b1;
    end
  end

  assign load_err = r_err;
`else
  logic w_unused_last;

  assign w_unused_last = s_last;
  assign load_err      = 1'b0;
`endif

  assign s_ready   = r_s_ready;
  assign busy      = r_busy;
  assign load_done = r_done;
  assign mat_ready = r_mat_ready;
  assign mat_ena   = r_wr;
  assign mat_wea   = r_wr;
  assign mat_enb   = r_wr;
  assign mat_web   = r_wr;
  assign mat_addra = r_addra;
  assign mat_addrb = r_addrb;
  assign mat_dina  = r_dina;
  assign mat_dinb  = r_dinb;

endmodule

// File: tb/tb_in_mat_loader.sv
// Bench for in_mat_loader: two instances (BASE_ADDR 0 and 16, NUM_WORDS 8) share one stimulus stream
// and are compared every cycle against a beat/pair scoreboard plus per-scenario end checks.
module tb_in_mat_loader;

  localparam int AW = linear_proj_pkg::ADDR_WIDTH_A;
  localparam int DW = linear_proj_pkg::DATA_WIDTH_A;
  localparam int NW = 8;

  logic          clk = 1'b0;
  logic          rst_n, load_start, s_valid, s_last;
  logic [DW-1:0] s_data;

  logic [1:0]    ready_v, busy_v, done_v, mready_v, err_v, ena_v, wea_v, enb_v, web_v;
  logic [AW-1:0] addra_v [2];
  logic [AW-1:0] addrb_v [2];
  logic [DW-1:0] dina_v  [2];
  logic [DW-1:0] dinb_v  [2];

  in_mat_loader #(.NUM_WORDS(NW), .BASE_ADDR(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .load_start(load_start),
    .s_valid(s_valid), .s_ready(ready_v[0]), .s_data(s_data), .s_last(s_last),
    .mat_ena(ena_v[0]), .mat_wea(wea_v[0]), .mat_addra(addra_v[0]), .mat_dina(dina_v[0]),
    .mat_enb(enb_v[0]), .mat_web(web_v[0]), .mat_addrb(addrb_v[0]), .mat_dinb(dinb_v[0]),
    .busy(busy_v[0]), .load_done(done_v[0]), .mat_ready(mready_v[0]), .load_err(err_v[0])
  );

  in_mat_loader #(.NUM_WORDS(NW), .BASE_ADDR(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .load_start(load_start),
    .s_valid(s_valid), .s_ready(ready_v[1]), .s_data(s_data), .s_last(s_last),
    .mat_ena(ena_v[1]), .mat_wea(wea_v[1]), .mat_addra(addra_v[1]), .mat_dina(dina_v[1]),
    .mat_enb(enb_v[1]), .mat_web(web_v[1]), .mat_addrb(addrb_v[1]), .mat_dinb(dinb_v[1]),
    .busy(busy_v[1]), .load_done(done_v[1]), .mat_ready(mready_v[1]), .load_err(err_v[1])
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  // Scoreboard: expected writes carry the cycle they must appear on (one after the odd beat).
  typedef struct {
    int            due;
    logic [AW-1:0] a;
    logic [DW-1:0] da;
    logic [DW-1:0] db;
  } wr_t;

  wr_t           wq[$];
  wr_t           wnew;
  int            cyc = 0;
  bit            m_on = 0;
  bit            m_wrote = 0;
  bit            e_ready = 0, e_busy = 0, e_err = 0, e_wr = 0;
  int            done_cyc = -1;
  int            beats = 0;
  logic [DW-1:0] held = '0;
  logic [AW-1:0] e_addra = '0, e_addrb = '0;
  logic [DW-1:0] e_dina = '0, e_dinb = '0;
  int            obs_wr = 0, obs_done = 0;

  always @(negedge clk) begin
    cyc++;
    e_wr = 1'b0;
    if (wq.size() > 0 && wq[0].due == cyc) begin
      e_wr    = 1'b1;
      m_wrote = 1'b1;
      e_addra = wq[0].a;
      e_addrb = wq[0].a + AW'(1);
      e_dina  = wq[0].da;
      e_dinb  = wq[0].db;
      void'(wq.pop_front());
    end
    if (m_on) begin
      for (int i = 0; i < 2; i++) begin
        logic [AW-1:0] off;
        off = (i == 1 && m_wrote) ? AW'(16) : AW'(0);
        nchk += 13;
        if (ready_v[i] !== e_ready) begin nerr++; $display("FAIL s_ready[%0d] cyc %0d: got %b want %b", i, cyc, ready_v[i], e_ready); end
        if (busy_v[i] !== e_busy) begin nerr++; $display("FAIL busy[%0d] cyc %0d: got %b want %b", i, cyc, busy_v[i], e_busy); end
        if (mready_v[i] !== (done_cyc >= 0 && cyc >= done_cyc)) begin nerr++; $display("FAIL mat_ready[%0d] cyc %0d: got %b", i, cyc, mready_v[i]); end
        if (done_v[i] !== (cyc == done_cyc)) begin nerr++; $display("FAIL load_done[%0d] cyc %0d: got %b want %b", i, cyc, done_v[i], cyc == done_cyc); end
        if (ena_v[i] !== e_wr) begin nerr++; $display("FAIL mat_ena[%0d] cyc %0d: got %b want %b", i, cyc, ena_v[i], e_wr); end
        if (wea_v[i] !== e_wr) begin nerr++; $display("FAIL mat_wea[%0d] cyc %0d: got %b want %b", i, cyc, wea_v[i], e_wr); end
        if (enb_v[i] !== e_wr) begin nerr++; $display("FAIL mat_enb[%0d] cyc %0d: got %b want %b", i, cyc, enb_v[i], e_wr); end
        if (web_v[i] !== e_wr) begin nerr++; $display("FAIL mat_web[%0d] cyc %0d: got %b want %b", i, cyc, web_v[i], e_wr); end
        if (addra_v[i] !== e_addra + off) begin nerr++; $display("FAIL mat_addra[%0d] cyc %0d: got %0d want %0d", i, cyc, addra_v[i], e_addra + off); end
        if (addrb_v[i] !== e_addrb + off) begin nerr++; $display("FAIL mat_addrb[%0d] cyc %0d: got %0d want %0d", i, cyc, addrb_v[i], e_addrb + off); end
        if (dina_v[i] !== e_dina) begin nerr++; $display("FAIL mat_dina[%0d] cyc %0d: got %h want %h", i, cyc, dina_v[i], e_dina); end
        if (dinb_v[i] !== e_dinb) begin nerr++; $display("FAIL mat_dinb[%0d] cyc %0d: got %h want %h", i, cyc, dinb_v[i], e_dinb); end
        if (err_v[i] !== e_err) begin nerr++; $display("FAIL load_err[%0d] cyc %0d: got %b want %b", i, cyc, err_v[i], e_err); end
      end
    end
    if (ena_v[0] === 1'b1) obs_wr++;
    if (done_v[0] === 1'b1) obs_done++;
    // Predict the effect of the inputs that the next rising edge will sample.
    if (!rst_n) begin
      m_on = 1; m_wrote = 0; wq.delete();
      e_ready = 0; e_busy = 0; e_err = 0; done_cyc = -1; beats = 0;
      e_addra = '0; e_addrb = '0; e_dina = '0; e_dinb = '0;
    end else if (s_valid && e_ready) begin
`ifdef MAT_LOADER_LAST_CHECK_EN
      if (s_last != (beats == NW - 1)) e_err = 1;
`endif
      if (beats % 2 == 0) begin
        held = s_data;
      end else begin
        wnew.due = cyc + 1; wnew.a = AW'(beats - 1); wnew.da = held; wnew.db = s_data;
        wq.push_back(wnew);
      end
      beats++;
      if (beats == NW) begin e_ready = 0; e_busy = 0; done_cyc = cyc + 2; end
    end else if (load_start && !e_busy && cyc != done_cyc - 1) begin
      e_ready = 1; e_busy = 1; beats = 0; done_cyc = -1; e_err = 0;
    end
  end

  task automatic drive(input bit v, input logic [DW-1:0] d, input bit l, input bit st);
    s_valid = v; s_data = d; s_last = l; load_start = st;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, '0, 0, 0);
  endtask

  task automatic test_reset;
    rst_n = 0;
    idle(3);
    rst_n = 1;
    idle(1);
    nchk += 5;
    if (ready_v !== 2'b00) begin nerr++; $display("FAIL reset_s_ready: got %b want 00", ready_v); end
    if (busy_v !== 2'b00) begin nerr++; $display("FAIL reset_busy: got %b want 00", busy_v); end
    if (mready_v !== 2'b00) begin nerr++; $display("FAIL reset_mat_ready: got %b want 00", mready_v); end
    if (ena_v !== 2'b00) begin nerr++; $display("FAIL reset_ena: got %b want 00", ena_v); end
    if (addrb_v[1] !== '0) begin nerr++; $display("FAIL reset_addrb: got %0d want 0", addrb_v[1]); end
  endtask

  task automatic test_back_to_back;
    int w0 = obs_wr, d0 = obs_done;
    drive(0, '0, 0, 1);
    for (int i = 0; i < NW; i++) drive(1, DW'(32'h10 + i), i == NW - 1, 0);
    idle(3);
    nchk += 3;
    if (obs_wr - w0 !== 4) begin nerr++; $display("FAIL b2b_writes: got %0d want 4", obs_wr - w0); end
    if (obs_done - d0 !== 1) begin nerr++; $display("FAIL b2b_done: got %0d want 1", obs_done - d0); end
    if (mready_v !== 2'b11) begin nerr++; $display("FAIL b2b_mat_ready: got %b want 11", mready_v); end
  endtask

  task automatic test_toggle_valid;
    int w0 = obs_wr, d0 = obs_done;
    drive(0, '0, 0, 1);
    for (int i = 0; i < 2 * NW; i++) drive(i % 2 == 0, DW'(32'h10 + i / 2), i / 2 == NW - 1, 0);
    idle(3);
    nchk += 2;
    if (obs_wr - w0 !== 4) begin nerr++; $display("FAIL toggle_writes: got %0d want 4", obs_wr - w0); end
    if (obs_done - d0 !== 1) begin nerr++; $display("FAIL toggle_done: got %0d want 1", obs_done - d0); end
  endtask

  task automatic test_held_valid;
    int w0 = obs_wr;
    drive(0, '0, 0, 1);
    for (int i = 0; i < NW + 4; i++) drive(1, DW'($urandom), i == NW - 1, 0);
    nchk += 2;
    if (ready_v !== 2'b00) begin nerr++; $display("FAIL held_s_ready: got %b want 00", ready_v); end
    if (obs_wr - w0 !== 4) begin nerr++; $display("FAIL held_writes: got %0d want 4", obs_wr - w0); end
    idle(2);
  endtask

  task automatic test_reset_mid;
    int w0 = obs_wr, d0;
    drive(0, '0, 0, 1);
    for (int i = 0; i < 3; i++) drive(1, DW'(32'h30 + i), 0, 0);
    rst_n = 0;
    idle(1);
    rst_n = 1;
    idle(3);
    nchk += 2;
    if (obs_wr - w0 !== 1) begin nerr++; $display("FAIL midrst_writes: got %0d want 1", obs_wr - w0); end
    if (mready_v !== 2'b00) begin nerr++; $display("FAIL midrst_mat_ready: got %b want 00", mready_v); end
    w0 = obs_wr; d0 = obs_done;
    drive(0, '0, 0, 1);
    for (int i = 0; i < NW; i++) drive(1, DW'(32'h20 + i), i == NW - 1, 0);
    idle(3);
    nchk += 2;
    if (obs_wr - w0 !== 4) begin nerr++; $display("FAIL restart_writes: got %0d want 4", obs_wr - w0); end
    if (obs_done - d0 !== 1) begin nerr++; $display("FAIL restart_done: got %0d want 1", obs_done - d0); end
  endtask

  task automatic test_start_ignored;
    int d0 = obs_done;
    drive(0, '0, 0, 1);
    for (int i = 0; i < NW; i++) drive(1, DW'($urandom), i == NW - 1, i == 3);
    drive(0, '0, 0, 1);
    idle(3);
    nchk += 2;
    if (obs_done - d0 !== 1) begin nerr++; $display("FAIL ignored_done: got %0d want 1", obs_done - d0); end
    if (mready_v !== 2'b11) begin nerr++; $display("FAIL ignored_mat_ready: got %b want 11", mready_v); end
    d0 = obs_done;
    drive(0, '0, 0, 1);
    nchk += 2;
    if (mready_v !== 2'b00) begin nerr++; $display("FAIL restart_mat_ready: got %b want 00", mready_v); end
    if (busy_v !== 2'b11) begin nerr++; $display("FAIL restart_busy: got %b want 11", busy_v); end
    for (int i = 0; i < NW; i++) drive(1, DW'($urandom), i == NW - 1, 0);
    idle(3);
    nchk++;
    if (obs_done - d0 !== 1) begin nerr++; $display("FAIL second_load_done: got %0d want 1", obs_done - d0); end
  endtask

  task automatic test_last_check;
    bit exp_err;
`ifdef MAT_LOADER_LAST_CHECK_EN
    exp_err = 1;
`else
    exp_err = 0;
`endif
    drive(0, '0, 0, 1);
    for (int i = 0; i < NW; i++) drive(1, DW'(32'h40 + i), i == 5, 0);
    idle(3);
    nchk += 2;
    if (err_v !== {2{exp_err}}) begin nerr++; $display("FAIL last_err_done: got %b want %b", err_v, {2{exp_err}}); end
    if (mready_v !== 2'b11) begin nerr++; $display("FAIL last_complete: got %b want 11", mready_v); end
    drive(0, '0, 0, 1);
    nchk++;
    if (err_v !== 2'b00) begin nerr++; $display("FAIL last_err_clear: got %b want 00", err_v); end
    for (int i = 0; i < NW; i++) drive(1, DW'($urandom), i == NW - 1, 0);
    idle(3);
  endtask

  task automatic test_random;
    for (int r = 0; r < 4; r++) begin
      int  n = 0, w0 = obs_wr, d0 = obs_done;
      bit  exp_err = 0;
      drive(0, '0, 0, 1);
      while (n < NW) begin
        bit v, l;
        v = ($urandom_range(0, 2) != 0);
        l = ($urandom_range(0, 9) == 0) ? (n != NW - 1) : (n == NW - 1);
        if (v && l != (n == NW - 1)) exp_err = 1;
        drive(v, DW'($urandom), l, 0);
        if (v) n++;
      end
`ifndef MAT_LOADER_LAST_CHECK_EN
      exp_err = 0;
`endif
      idle(3);
      nchk += 3;
      if (obs_wr - w0 !== 4) begin nerr++; $display("FAIL rand%0d_writes: got %0d want 4", r, obs_wr - w0); end
      if (obs_done - d0 !== 1) begin nerr++; $display("FAIL rand%0d_done: got %0d want 1", r, obs_done - d0); end
      if (err_v !== {2{exp_err}}) begin nerr++; $display("FAIL rand%0d_err: got %b want %b", r, err_v, {2{exp_err}}); end
    end
  endtask

  initial begin
    rst_n = 0; load_start = 0; s_valid = 0; s_last = 0; s_data = '0;
    test_reset;
    test_back_to_back;
    test_toggle_valid;
    test_held_valid;
    test_reset_mid;
    test_start_ignored;
    test_last_check;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
